// File: rtl/beep_seq_pkg.sv
// beep_seq_pkg: note codes, tone half-periods, source/state encodings and pattern step ROM.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package beep_seq_pkg;

  // Note codes: 0 is silence, 1..8 run do..high-do
  localparam logic [3:0] NOTE_SILENCE = 4'd0;
  localparam logic [3:0] NOTE_DO      = 4'd1;
  localparam logic [3:0] NOTE_RE      = 4'd2;
  localparam logic [3:0] NOTE_MI      = 4'd3;
  localparam logic [3:0] NOTE_FA      = 4'd4;
  localparam logic [3:0] NOTE_SO      = 4'd5;
  localparam logic [3:0] NOTE_LA      = 4'd6;
  localparam logic [3:0] NOTE_TI      = 4'd7;
  localparam logic [3:0] NOTE_HI_DO   = 4'd8;

  // Who currently owns the buzzer
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_CLICK = 2'd1,
    SRC_CHIME = 2'd2,
    SRC_ALARM = 2'd3
  } src_e;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TONE = 3'd2,
    ST_GAP  = 3'd3,
    ST_END  = 3'd4
  } state_e;

  // One pattern step: note, tone length and gap length in ticks, last-step flag
  typedef struct packed {
    logic [3:0] note;
    logic [7:0] tone_ticks;
    logic [7:0] gap_ticks;
    logic       last;
  } step_t;

  localparam step_t CLICK_STEP  = '{note: NOTE_DO,    tone_ticks: 8'd5,  gap_ticks: 8'd0,  last: 1'b1};
  localparam step_t CHIME_STEP0 = '{note: NOTE_SO,    tone_ticks: 8'd20, gap_ticks: 8'd5,  last: 1'b0};
  localparam step_t CHIME_STEP1 = '{note: NOTE_MI,    tone_ticks: 8'd20, gap_ticks: 8'd5,  last: 1'b0};
  localparam step_t CHIME_STEP2 = '{note: NOTE_DO,    tone_ticks: 8'd20, gap_ticks: 8'd5,  last: 1'b1};
  // The alarm last flag depends on the repeat counter and is patched in by the sequencer
  localparam step_t ALARM_STEP  = '{note: NOTE_HI_DO, tone_ticks: 8'd25, gap_ticks: 8'd25, last: 1'b0};

  // Half-period in clock cycles minus one; each output half-wave lasts HALF+1 cycles
  function automatic logic [15:0] half_period(input logic [3:0] note);
    logic [15:0] half;
    half = 16'd0;
    case (note)
      NOTE_DO:    half = 16'd47774;
      NOTE_RE:    half = 16'd42568;
      NOTE_MI:    half = 16'd37919;
      NOTE_FA:    half = 16'd35791;
      NOTE_SO:    half = 16'd31888;
      NOTE_LA:    half = 16'd28409;
      NOTE_TI:    half = 16'd25309;
      NOTE_HI_DO: half = 16'd23889;
      default:    half = 16'd0;
    endcase
    return half;
  endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// beep_tone_gen: square-wave divider turning a note code into the piezo drive signal.
// Latency: a note change forces the output low in the same cycle; first edge HALF+1 cycles later.
// Backpressure: none; follows the note input every cycle.
module beep_tone_gen
  import beep_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] note,
  output logic       beep
);

  logic [15:0] cnt_q, cnt_d;
  logic        beep_q, beep_d;
  logic [3:0]  prev_note_q, prev_note_d;
  logic [15:0] half;
  logic        change;
  logic [15:0] cnt_eff;
  logic        beep_eff;

  assign half = half_period(note);

  // Divider: a note change counts as cycle 0 of a fresh low half-wave
  always_comb begin
    change      = (note != prev_note_q);
    cnt_eff     = change ? 16'd0 : cnt_q;
    beep_eff    = change ? 1'b0 : beep_q;
    prev_note_d = note;
    cnt_d       = 16'd0;
    beep_d      = 1'b0;
    if (note == NOTE_SILENCE) begin
      cnt_d  = 16'd0;
      beep_d = 1'b0;
    end else if (cnt_eff == half) begin
      cnt_d  = 16'd0;
      beep_d = ~beep_eff;
    end else begin
      cnt_d  = cnt_eff + 16'd1;
      beep_d = beep_eff;
    end
  end

  assign beep = beep_eff & (note != NOTE_SILENCE);

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 16'd0;
      beep_q      <= 1'b0;
      prev_note_q <= NOTE_SILENCE;
    end else begin
      cnt_q       <= cnt_d;
      beep_q      <= beep_d;
      prev_note_q <= prev_note_d;
    end
  end

endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer: arbitrates click/chime/alarm onto one piezo and plays their note patterns.
// Latency: request in cycle N -> BUSY/NOTE in cycle N+2; a k-tick step lasts k*TICK_DIV cycles after LOAD.
// Backpressure: alarm/chime requests are sticky; clicks are dropped while busy or when others wait.
// Build option BEEP_SEQ_MUTE_EN adds a MUTE input that silences BEEP without touching sequencing.
module beep_sequencer
  import beep_seq_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int ALARM_REPS = 8
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       CLICK_REQ,
  input  logic       CHIME_REQ,
  input  logic       ALARM_REQ,
  input  logic       ALARM_STOP,
`ifdef BEEP_SEQ_MUTE_EN
  input  logic       MUTE,
`endif
  output logic       BEEP,
  output logic       BUSY,
  output logic [1:0] ACTIVE_SRC,
  output logic [3:0] NOTE,
  output logic       DONE
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [7:0]    REP_LAST  = 8'(ALARM_REPS - 1);

  state_e        state_q, state_d;
  src_e          src_q, src_d;
  src_e          act_src_q, act_src_d;
  logic [1:0]    step_q, step_d;
  logic [7:0]    rep_q, rep_d;
  logic [7:0]    tone_len_q, tone_len_d;
  logic [7:0]    gap_len_q, gap_len_d;
  logic          last_q, last_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    ph_cnt_q, ph_cnt_d;
  logic [3:0]    note_q, note_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          alarm_pend_q, alarm_pend_d;
  logic          chime_pend_q, chime_pend_d;
  logic          click_pend_q, click_pend_d;

  step_t sel_step;
  logic  tick;
  logic  alarm_any, chime_any, click_ok;
  logic  in_pattern;
  logic  step_end, go_end;
  logic  tone_beep;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign alarm_any  = alarm_pend_q | ALARM_REQ;
  assign chime_any  = chime_pend_q | CHIME_REQ;
  // A click only gets in when nothing is playing and nothing else is waiting
  assign click_ok   = CLICK_REQ & ~busy_q & ~alarm_any & ~chime_any;
  assign in_pattern = (state_q == ST_LOAD) || (state_q == ST_TONE) || (state_q == ST_GAP);

  // Pattern ROM lookup for the step about to be loaded
  always_comb begin
    sel_step = CLICK_STEP;
    case (src_q)
      SRC_CHIME: begin
        case (step_q)
          2'd0:    sel_step = CHIME_STEP0;
          2'd1:    sel_step = CHIME_STEP1;
          default: sel_step = CHIME_STEP2;
        endcase
      end
      SRC_ALARM: begin
        sel_step      = ALARM_STEP;
        sel_step.last = (rep_q == REP_LAST);
      end
      default: sel_step = CLICK_STEP;
    endcase
  end

  // Next-state, pending-flag and output logic of the sequencer
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    act_src_d    = act_src_q;
    step_d       = step_q;
    rep_d        = rep_q;
    tone_len_d   = tone_len_q;
    gap_len_d    = gap_len_q;
    last_d       = last_q;
    tick_cnt_d   = '0;
    ph_cnt_d     = ph_cnt_q;
    note_d       = note_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    alarm_pend_d = alarm_any;
    chime_pend_d = chime_any;
    click_pend_d = click_pend_q | click_ok;
    step_end     = 1'b0;
    go_end       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ph_cnt_d = 8'd0;
        step_d   = 2'd0;
        rep_d    = 8'd0;
        if (alarm_any) begin
          state_d      = ST_LOAD;
          src_d        = SRC_ALARM;
          alarm_pend_d = 1'b0;
        end else if (chime_any) begin
          state_d      = ST_LOAD;
          src_d        = SRC_CHIME;
          chime_pend_d = 1'b0;
        end else if (click_pend_q | click_ok) begin
          state_d      = ST_LOAD;
          src_d        = SRC_CLICK;
          click_pend_d = 1'b0;
        end
      end
      ST_LOAD: begin
        tone_len_d = sel_step.tone_ticks;
        gap_len_d  = sel_step.gap_ticks;
        last_d     = sel_step.last;
        note_d     = sel_step.note;
        act_src_d  = src_q;
        busy_d     = 1'b1;
        ph_cnt_d   = 8'd0;
        state_d    = ST_TONE;
      end
      ST_TONE: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
        if (tick) begin
          if (ph_cnt_q == tone_len_q - 8'd1) begin
            ph_cnt_d = 8'd0;
            if (gap_len_q != 8'd0) begin
              state_d = ST_GAP;
              note_d  = NOTE_SILENCE;
            end else begin
              step_end = 1'b1;
            end
          end else begin
            ph_cnt_d = ph_cnt_q + 8'd1;
          end
        end
      end
      ST_GAP: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
        if (tick) begin
          if (ph_cnt_q == gap_len_q - 8'd1) begin
            ph_cnt_d = 8'd0;
            step_end = 1'b1;
          end else begin
            ph_cnt_d = ph_cnt_q + 8'd1;
          end
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Step finished: either the pattern is over or the next step is loaded
    if (step_end) begin
      if (last_q) begin
        go_end = 1'b1;
      end else begin
        state_d = ST_LOAD;
        if (src_q == SRC_ALARM) rep_d = rep_q + 8'd1;
        else                    step_d = step_q + 2'd1;
      end
    end

    // An alarm aborts a click or chime silently; the next LOAD starts the alarm
    if (in_pattern && (src_q == SRC_CLICK || src_q == SRC_CHIME) && alarm_any) begin
      state_d      = ST_LOAD;
      src_d        = SRC_ALARM;
      step_d       = 2'd0;
      rep_d        = 8'd0;
      alarm_pend_d = 1'b0;
    end

    // User silence only acts on a playing alarm
    if (in_pattern && act_src_q == SRC_ALARM && ALARM_STOP) begin
      go_end       = 1'b1;
      alarm_pend_d = 1'b0;
    end

    if (go_end) begin
      state_d   = ST_END;
      src_d     = SRC_NONE;
      act_src_d = SRC_NONE;
      note_d    = NOTE_SILENCE;
      busy_d    = 1'b0;
      done_d    = 1'b1;
    end
  end

  // Sequencer state registers
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_NONE;
      act_src_q    <= SRC_NONE;
      step_q       <= 2'd0;
      rep_q        <= 8'd0;
      tone_len_q   <= 8'd0;
      gap_len_q    <= 8'd0;
      last_q       <= 1'b0;
      tick_cnt_q   <= '0;
      ph_cnt_q     <= 8'd0;
      note_q       <= NOTE_SILENCE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      alarm_pend_q <= 1'b0;
      chime_pend_q <= 1'b0;
      click_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      act_src_q    <= act_src_d;
      step_q       <= step_d;
      rep_q        <= rep_d;
      tone_len_q   <= tone_len_d;
      gap_len_q    <= gap_len_d;
      last_q       <= last_d;
      tick_cnt_q   <= tick_cnt_d;
      ph_cnt_q     <= ph_cnt_d;
      note_q       <= note_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      alarm_pend_q <= alarm_pend_d;
      chime_pend_q <= chime_pend_d;
      click_pend_q <= click_pend_d;
    end
  end

  beep_tone_gen u_tone (
    .clk  (CLK_50M),
    .rst  (RST),
    .note (note_q),
    .beep (tone_beep)
  );

`ifdef BEEP_SEQ_MUTE_EN
  assign BEEP = tone_beep & ~MUTE;
`else
  assign BEEP = tone_beep;
`endif

  assign BUSY       = busy_q;
  assign ACTIVE_SRC = act_src_q;
  assign NOTE       = note_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// tb_beep_sequencer: directed checks of arbitration, pattern timing, pre-emption, stop, reset and tone output.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_beep_sequencer;

  logic       clk;
  logic       rst;
  logic       click_req, chime_req, alarm_req, alarm_stop, mute;
  logic       beep, busy, done;
  logic [1:0] active_src;
  logic [3:0] note;

  logic       alarm_req2, alarm_stop2, mute2;
  logic       beep2, busy2, done2;
  logic [1:0] active_src2;
  logic [3:0] note2;
  logic       zero_in;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beep_sequencer #(.TICK_DIV(10), .ALARM_REPS(2)) dut (
    .CLK_50M    (clk),
    .RST        (rst),
    .CLICK_REQ  (click_req),
    .CHIME_REQ  (chime_req),
    .ALARM_REQ  (alarm_req),
    .ALARM_STOP (alarm_stop),
`ifdef BEEP_SEQ_MUTE_EN
    .MUTE       (mute),
`endif
    .BEEP       (beep),
    .BUSY       (busy),
    .ACTIVE_SRC (active_src),
    .NOTE       (note),
    .DONE       (done)
  );

  // Long ticks so a full tone half-period fits inside one alarm beep
  beep_sequencer #(.TICK_DIV(2000), .ALARM_REPS(1)) dut2 (
    .CLK_50M    (clk),
    .RST        (rst),
    .CLICK_REQ  (zero_in),
    .CHIME_REQ  (zero_in),
    .ALARM_REQ  (alarm_req2),
    .ALARM_STOP (alarm_stop2),
`ifdef BEEP_SEQ_MUTE_EN
    .MUTE       (mute2),
`endif
    .BEEP       (beep2),
    .BUSY       (busy2),
    .ACTIVE_SRC (active_src2),
    .NOTE       (note2),
    .DONE       (done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Length of the current run of NOTE==n, stopping early on DONE
  task automatic measure(input logic [3:0] n, input logic [1:0] src,
                         output int len, output int src_bad, output int beep_hi);
    len = 0; src_bad = 0; beep_hi = 0;
    while (note === n && done === 1'b0 && len < 1000) begin
      if (active_src !== src) src_bad++;
      if (beep !== 1'b0) beep_hi++;
      len++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; click_req = 0; chime_req = 0; alarm_req = 0; alarm_stop = 0; mute = 0;
    alarm_req2 = 0; alarm_stop2 = 0; mute2 = 0; zero_in = 0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (note !== 4'd0) begin failures++; $display("FAIL reset_note got=%0d exp=0", note); end
    checks++; if (active_src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", active_src); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", done); end
    checks++; if (beep !== 1'b0) begin failures++; $display("FAIL reset_beep got=%0d exp=0", beep); end
  endtask

  task automatic test_click();
    int len, sb, bh;
    click_req = 1'b1; tick(); click_req = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL click_busy_n1 got=%0d exp=0", busy); end
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL click_busy_n2 got=%0d exp=1", busy); end
    checks++; if (note !== 4'd1) begin failures++; $display("FAIL click_note got=%0d exp=1", note); end
    checks++; if (active_src !== 2'd1) begin failures++; $display("FAIL click_src got=%0d exp=1", active_src); end
    measure(4'd1, 2'd1, len, sb, bh);
    checks++; if (len != 50) begin failures++; $display("FAIL click_len got=%0d exp=50", len); end
    checks++; if (sb != 0) begin failures++; $display("FAIL click_src_run got=%0d exp=0", sb); end
    checks++; if (bh != 0) begin failures++; $display("FAIL click_beep got=%0d exp=0", bh); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL click_done got=%0d exp=1", done); end
    checks++; if ({busy, note, active_src} !== 7'd0) begin failures++; $display("FAIL click_end_outs got=%0h exp=0", {busy, note, active_src}); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL click_done_pulse got=%0d exp=0", done); end
  endtask

  task automatic test_stop_ignored_for_click();
    int len, sb, bh;
    click_req = 1'b1; tick(); click_req = 1'b0; tick();
    alarm_stop = 1'b1; tick(); alarm_stop = 1'b0;
    measure(4'd1, 2'd1, len, sb, bh);
    checks++; if (len != 49) begin failures++; $display("FAIL stop_click_len got=%0d exp=49", len); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stop_click_done got=%0d exp=1", done); end
    tick();
  endtask

  task automatic test_chime();
    int exp_n[6];
    int exp_l[6];
    int len, sb, bh;
    exp_n = '{5, 0, 3, 0, 1, 0};
    // Inner gaps include the following LOAD cycle; the last gap ends at DONE
    exp_l = '{200, 51, 200, 51, 200, 50};
    chime_req = 1'b1; tick(); chime_req = 1'b0; tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL chime_busy got=%0d exp=1", busy); end
    for (int i = 0; i < 6; i++) begin
      measure(4'(exp_n[i]), 2'd2, len, sb, bh);
      checks++; if (len != exp_l[i]) begin failures++; $display("FAIL chime_run%0d got=%0d exp=%0d", i, len, exp_l[i]); end
      checks++; if (sb != 0) begin failures++; $display("FAIL chime_src%0d got=%0d exp=0", i, sb); end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL chime_done got=%0d exp=1", done); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL chime_done_pulse got=%0d exp=0", done); end
  endtask

  task automatic test_alarm_preempt();
    int exp_n[4];
    int exp_l[4];
    int len, sb, bh, busy_seen;
    exp_n = '{8, 0, 8, 0};
    exp_l = '{250, 251, 250, 250};
    chime_req = 1'b1; tick(); chime_req = 1'b0; tick();
    measure(4'd5, 2'd2, len, sb, bh);
    measure(4'd0, 2'd2, len, sb, bh);
    checks++; if (note !== 4'd3) begin failures++; $display("FAIL pre_note3 got=%0d exp=3", note); end
    repeat (10) tick();
    alarm_req = 1'b1; tick(); alarm_req = 1'b0;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL pre_no_done got=%0d exp=0", done); end
    tick();
    checks++; if (active_src !== 2'd3) begin failures++; $display("FAIL pre_src got=%0d exp=3", active_src); end
    checks++; if (note !== 4'd8) begin failures++; $display("FAIL pre_note got=%0d exp=8", note); end
    for (int i = 0; i < 4; i++) begin
      measure(4'(exp_n[i]), 2'd3, len, sb, bh);
      checks++; if (len != exp_l[i]) begin failures++; $display("FAIL pre_run%0d got=%0d exp=%0d", i, len, exp_l[i]); end
      checks++; if (sb != 0) begin failures++; $display("FAIL pre_src%0d got=%0d exp=0", i, sb); end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL pre_done got=%0d exp=1", done); end
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (busy !== 1'b0) busy_seen++; end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL pre_chime_replay got=%0d exp=0", busy_seen); end
  endtask

  task automatic test_back_to_back();
    int exp_n[4];
    int exp_l[4];
    int len, sb, bh, waited, busy_seen;
    exp_n = '{8, 0, 8, 0};
    exp_l = '{250, 251, 250, 250};
    alarm_req = 1'b1; chime_req = 1'b1; tick();
    alarm_req = 1'b0; chime_req = 1'b0; click_req = 1'b1; tick();
    click_req = 1'b0;
    checks++; if (active_src !== 2'd3) begin failures++; $display("FAIL b2b_alarm_src got=%0d exp=3", active_src); end
    for (int i = 0; i < 4; i++) begin
      measure(4'(exp_n[i]), 2'd3, len, sb, bh);
      checks++; if (len != exp_l[i]) begin failures++; $display("FAIL b2b_run%0d got=%0d exp=%0d", i, len, exp_l[i]); end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_alarm_done got=%0d exp=1", done); end
    tick(); tick(); tick();
    checks++; if (active_src !== 2'd2) begin failures++; $display("FAIL b2b_chime_src got=%0d exp=2", active_src); end
    checks++; if (note !== 4'd5) begin failures++; $display("FAIL b2b_chime_note got=%0d exp=5", note); end
    waited = 0;
    while (done !== 1'b1 && waited < 2000) begin tick(); waited++; end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_chime_done got=%0d exp=1", done); end
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (busy !== 1'b0) busy_seen++; end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL b2b_click_dropped got=%0d exp=0", busy_seen); end
  endtask

  task automatic test_alarm_stop();
    int busy_seen;
    alarm_req = 1'b1; tick(); alarm_req = 1'b0; tick();
    checks++; if (note !== 4'd8) begin failures++; $display("FAIL stop_note8 got=%0d exp=8", note); end
    repeat (30) tick();
    alarm_stop = 1'b1; tick(); alarm_stop = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stop_done got=%0d exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%0d exp=0", busy); end
    checks++; if (beep !== 1'b0) begin failures++; $display("FAIL stop_beep got=%0d exp=0", beep); end
    checks++; if ({note, active_src} !== 6'd0) begin failures++; $display("FAIL stop_outs got=%0h exp=0", {note, active_src}); end
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if ((busy | done) !== 1'b0) busy_seen++; end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL stop_quiet got=%0d exp=0", busy_seen); end
  endtask

  task automatic test_reset_mid();
    int seen;
    chime_req = 1'b1; tick(); chime_req = 1'b0; tick();
    repeat (100) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%0d exp=1", busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({busy, note, active_src, done, beep} !== 9'd0) begin failures++; $display("FAIL rstmid_outs got=%0h exp=0", {busy, note, active_src, done, beep}); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if ((busy | done) !== 1'b0) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", seen); end
  endtask

  task automatic test_tone();
    int len;
    alarm_req2 = 1'b1; tick(); alarm_req2 = 1'b0;
    len = 0;
    while (note2 !== 4'd8 && len < 10) begin tick(); len++; end
    checks++; if (note2 !== 4'd8) begin failures++; $display("FAIL tone_note got=%0d exp=8", note2); end
    // High-do half-period 23889 -> each half-wave is 23890 cycles
    len = 0;
    while (beep2 === 1'b0 && len < 30000) begin tick(); len++; end
    checks++; if (len != 23890) begin failures++; $display("FAIL tone_low_half got=%0d exp=23890", len); end
`ifdef BEEP_SEQ_MUTE_EN
    mute2 = 1'b1; #1;
    checks++; if (beep2 !== 1'b0) begin failures++; $display("FAIL mute_beep got=%0d exp=0", beep2); end
    checks++; if (note2 !== 4'd8) begin failures++; $display("FAIL mute_note got=%0d exp=8", note2); end
    mute2 = 1'b0; #1;
`endif
    len = 0;
    while (beep2 === 1'b1 && len < 30000) begin tick(); len++; end
    checks++; if (len != 23890) begin failures++; $display("FAIL tone_high_half got=%0d exp=23890", len); end
    alarm_stop2 = 1'b1; tick(); alarm_stop2 = 1'b0;
    checks++; if (done2 !== 1'b1) begin failures++; $display("FAIL tone_stop_done got=%0d exp=1", done2); end
    checks++; if ({beep2, note2, busy2} !== 6'd0) begin failures++; $display("FAIL tone_stop_outs got=%0h exp=0", {beep2, note2, busy2}); end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    tick();
    test_click();
    test_stop_ignored_for_click();
    test_chime();
    tick();
    test_alarm_preempt();
    test_back_to_back();
    test_alarm_stop();
    test_reset_mid();
    test_tone();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
